// File: rtl/ras_checkpoint_queue.sv
// ras_checkpoint_queue: circular checkpoint store of speculative RAS {ptr, top} state
// alloc*: save a checkpoint at allocTag (tail); commit: release the head slot
// recover*: restore slot recoverTag next cycle and drop younger slots; flushAll: drop all
// restore*/recoverError: registered single-cycle pulses; count: live checkpoints
module ras_checkpoint_queue #(
  parameter int ENTRY_NUM = 16,
  parameter int RAS_PTR_WIDTH = 4,
  parameter int PC_WIDTH = 32,
  localparam int TAG_WIDTH = $clog2(ENTRY_NUM),
  localparam int COUNT_WIDTH = TAG_WIDTH + 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     allocValid,
  input  logic [RAS_PTR_WIDTH-1:0] allocPtr,
  input  logic [PC_WIDTH-1:0]      allocTop,
  output logic                     allocReady,
  output logic [TAG_WIDTH-1:0]     allocTag,
  input  logic                     commitValid,
  input  logic                     recoverValid,
  input  logic [TAG_WIDTH-1:0]     recoverTag,
  input  logic                     flushAll,
  output logic                     restoreValid,
  output logic [RAS_PTR_WIDTH-1:0] restorePtr,
  output logic [PC_WIDTH-1:0]      restoreTop,
  output logic                     recoverError,
  output logic [COUNT_WIDTH-1:0]   count
);
  logic [RAS_PTR_WIDTH-1:0] ptr_mem [ENTRY_NUM];
  logic [PC_WIDTH-1:0] top_mem [ENTRY_NUM];
  logic [ENTRY_NUM-1:0] valid, valid_c, keep, alloc_hot;
  logic [TAG_WIDTH-1:0] head, tail, head_n, span;
  logic alloc_ok, commit_ok, rec_ok, rec_err;
  assign allocReady = count != COUNT_WIDTH'(ENTRY_NUM);
  assign allocTag = tail;
  // recover is judged against the valid bits left after a same-cycle commit;
  // keep[] marks slots no younger than recoverTag, measured from the new head
  always_comb begin
    alloc_ok = allocValid && allocReady && !recoverValid && !flushAll;
    commit_ok = commitValid && count != '0 && !flushAll;
    head_n = commit_ok ? head + TAG_WIDTH'(1) : head;
    valid_c = valid;
    valid_c[head] = valid[head] && !commit_ok;
    alloc_hot = '0;
    alloc_hot[tail] = alloc_ok;
    rec_ok = recoverValid && !flushAll && valid_c[recoverTag];
    rec_err = recoverValid && !flushAll && !valid_c[recoverTag];
    span = recoverTag - head_n;
    for (int i = 0; i < ENTRY_NUM; i++) keep[i] = TAG_WIDTH'(TAG_WIDTH'(i) - head_n) <= span;
  end
  always_ff @(posedge clk) begin
    if (alloc_ok) begin
      ptr_mem[tail] <= allocPtr;
      top_mem[tail] <= allocTop;
    end
  end
  // span+1 widened to COUNT_WIDTH yields ENTRY_NUM when a full queue recovers its youngest slot
  always_ff @(posedge clk) begin
    if (rst || flushAll) begin
      head <= '0;
      tail <= '0;
      count <= '0;
      valid <= '0;
      restoreValid <= 1'b0;
      recoverError <= 1'b0;
    end else begin
      restoreValid <= rec_ok;
      recoverError <= rec_err;
      head <= head_n;
      tail <= rec_ok ? recoverTag + TAG_WIDTH'(1) : tail + TAG_WIDTH'(alloc_ok);
      count <= rec_ok ? {1'b0, span} + COUNT_WIDTH'(1) : count + COUNT_WIDTH'(alloc_ok) - COUNT_WIDTH'(commit_ok);
      valid <= rec_ok ? valid_c & keep : valid_c | alloc_hot;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      restorePtr <= '0;
      restoreTop <= '0;
    end else if (rec_ok) begin
      restorePtr <= ptr_mem[recoverTag];
      restoreTop <= top_mem[recoverTag];
    end
  end
endmodule

// File: tb/tb_ras_checkpoint_queue.sv
// tb_ras_checkpoint_queue: scoreboard bench for ras_checkpoint_queue against a queue-based model
module tb_ras_checkpoint_queue;
  localparam int N = 16;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic allocValid = 1'b0, commitValid = 1'b0, recoverValid = 1'b0, flushAll = 1'b0;
  logic [3:0] allocPtr = '0, recoverTag = '0, allocTag, restorePtr;
  logic [31:0] allocTop = '0, restoreTop;
  logic allocReady, restoreValid, recoverError;
  logic [4:0] count;
  ras_checkpoint_queue dut (
    .clk(clk), .rst(rst), .allocValid(allocValid), .allocPtr(allocPtr), .allocTop(allocTop),
    .allocReady(allocReady), .allocTag(allocTag), .commitValid(commitValid),
    .recoverValid(recoverValid), .recoverTag(recoverTag), .flushAll(flushAll),
    .restoreValid(restoreValid), .restorePtr(restorePtr), .restoreTop(restoreTop),
    .recoverError(recoverError), .count(count)
  );
  always #5 clk = ~clk;
  typedef struct {logic [3:0] p; logic [31:0] t;} ent_t;
  typedef struct {bit err; logic [3:0] p; logic [31:0] t;} exp_t;
  ent_t mq[$];
  exp_t expq[$];
  int mh = 0;
  int passed = 0, total = 0;
  bit chk_en = 0;
  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    total++;
    if (a === e) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
  endtask
  always @(negedge clk) begin
    if (chk_en) begin
      exp_t e;
      chk("count", 64'(count), 64'(mq.size()));
      chk("allocReady", 64'(allocReady), 64'(mq.size() != N));
      chk("allocTag", 64'(allocTag), 64'((mh + mq.size()) % N));
      if (restoreValid || recoverError) begin
        if (expq.size() == 0) chk("unexpected_pulse", {restoreValid, recoverError}, 0);
        else begin
          e = expq.pop_front();
          chk("recoverError", 64'(recoverError), 64'(e.err));
          chk("restoreValid", 64'(restoreValid), 64'(!e.err));
          if (!e.err) begin
            chk("restorePtr", 64'(restorePtr), 64'(e.p));
            chk("restoreTop", 64'(restoreTop), 64'(e.t));
          end
        end
      end else if (expq.size() != 0) begin
        e = expq.pop_front();
        chk("missing_pulse", 0, 1);
      end
    end
  end
  task automatic step(input bit r, input bit av, input logic [3:0] ap, input logic [31:0] at,
                      input bit cv, input bit rv, input logic [3:0] rt, input bit fl);
    bit a_ok, c_ok;
    int k;
    ent_t en;
    exp_t ex;
    @(negedge clk);
    #1;
    rst = r; allocValid = av; allocPtr = ap; allocTop = at;
    commitValid = cv; recoverValid = rv; recoverTag = rt; flushAll = fl;
    if (r || fl) begin
      mq.delete();
      mh = 0;
      return;
    end
    a_ok = av && mq.size() < N && !rv;
    c_ok = cv && mq.size() > 0;
    if (c_ok) begin
      void'(mq.pop_front());
      mh = (mh + 1) % N;
    end
    if (rv) begin
      k = (int'(rt) - mh + N) % N;
      if (k < mq.size()) begin
        ex.err = 0; ex.p = mq[k].p; ex.t = mq[k].t;
        while (mq.size() > k + 1) void'(mq.pop_back());
      end else begin
        ex.err = 1; ex.p = '0; ex.t = '0;
      end
      expq.push_back(ex);
    end
    if (a_ok) begin
      en.p = ap; en.t = at;
      mq.push_back(en);
    end
  endtask
  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic reset();
    step(1, 0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic alloc(input logic [3:0] p, input logic [31:0] t);
    step(0, 1, p, t, 0, 0, 0, 0);
  endtask
  task automatic commit();
    step(0, 0, 0, 0, 1, 0, 0, 0);
  endtask
  task automatic recover(input logic [3:0] t);
    step(0, 0, 0, 0, 0, 1, t, 0);
  endtask
  initial begin
    logic [3:0] tg;
    repeat (2) @(negedge clk);
    chk_en = 1;
    chk("reset_restorePtr", 64'(restorePtr), 0);
    chk("reset_restoreTop", 64'(restoreTop), 0);
    chk("reset_pulses", {restoreValid, recoverError}, 0);
    reset();
    alloc(1, 32'h100); alloc(2, 32'h200); alloc(3, 32'h300);
    recover(1); idle();
    reset();
    for (int i = 0; i < 17; i++) alloc(4'(i), 32'h1000 + 32'(i));
    commit(); commit(); commit(); commit();
    for (int i = 0; i < 4; i++) alloc(4'(i + 8), 32'h2000 + 32'(i));
    recover(2); idle();
    reset();
    alloc(7, 32'h700);
    step(0, 1, 9, 32'h900, 0, 1, 0, 0); idle();
    reset();
    recover(5); idle();
    reset();
    for (int i = 0; i < 5; i++) alloc(4'(i), 32'h50 + 32'(i));
    step(0, 1, 3, 32'h33, 1, 1, 2, 1); idle();
    reset();
    for (int i = 0; i < 3000; i++) begin
      if (mq.size() > 0 && $urandom_range(3) != 0) tg = 4'((mh + int'($urandom_range(mq.size() - 1))) % N);
      else tg = 4'($urandom_range(N - 1));
      step($urandom_range(199) == 0, $urandom_range(9) < 6, 4'($urandom), $urandom,
           $urandom_range(19) < 7, $urandom_range(9) == 0, tg, $urandom_range(49) == 0);
    end
    idle(); idle();
    @(negedge clk);
    #2;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
